// File: rtl/vga_wb_fetch.sv
// Wishbone read master streaming a frame buffer into a show-ahead pixel FIFO.
// Define VGA_WB_FETCH_DBLBUF_EN to alternate frames between vbase0_i and vbase1_i.
module vga_wb_fetch #(
   parameter int AWIDTH  = 32,
   parameter int DWIDTH  = 32,
   parameter int FIFO_AW = 4,
   parameter int BURST   = 8
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                ctrl_en_i,
   input  logic [AWIDTH-1:0]   vbase0_i,
`ifdef VGA_WB_FETCH_DBLBUF_EN
   input  logic [AWIDTH-1:0]   vbase1_i,
   output logic                vbsel_o,
`endif
   input  logic [AWIDTH-1:0]   vlen_i,
   output logic [AWIDTH-1:0]   wb_adr_o,
   input  logic [DWIDTH-1:0]   wb_dat_i,
   output logic [DWIDTH/8-1:0] wb_sel_o,
   output logic                wb_we_o,
   output logic                wb_stb_o,
   output logic                wb_cyc_o,
   input  logic                wb_ack_i,
   input  logic                wb_err_i,
   input  logic                fifo_rd_i,
   output logic [DWIDTH-1:0]   fifo_q_o,
   output logic                fifo_empty_o,
   output logic                frame_o,
   output logic                err_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int LW    = FIFO_AW + 1;
   localparam int BW    = $clog2(BURST + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUS} state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [AWIDTH-1:0]   r_adr;
   logic [AWIDTH-1:0]   r_count;
   logic [AWIDTH-1:0]   w_reloadBase;
   logic [BW-1:0]       r_beat;
   logic                r_frame;
   logic                r_err;
   logic                r_stop;
   logic [DWIDTH-1:0]   r_mem [DEPTH];
   logic [FIFO_AW-1:0]  r_wptr;
   logic [FIFO_AW-1:0]  r_rptr;
   logic [LW-1:0]       r_level;
   logic [LW-1:0]       w_free;
   logic                w_inBus;
   logic                w_ack;
   logic                w_err;
   logic                w_lastWord;
   logic                w_burstEnd;
   logic                w_room;
   logic                w_start;
   logic                w_push;
   logic                w_pop;

   assign w_inBus    = (r_state == S_BUS);
   assign w_err      = w_inBus && wb_err_i;
   assign w_ack      = w_inBus && wb_ack_i && !wb_err_i;
   assign w_lastWord = (r_count == (vlen_i - AWIDTH'(1)));
   assign w_burstEnd = w_ack && ((r_beat == BW'(BURST - 1)) || w_lastWord);
   assign w_free     = LW'(DEPTH) - r_level;
   assign w_room     = (w_free >= LW'(BURST));
   assign w_start    = ctrl_en_i && (vlen_i != '0) && !r_err;
   assign w_push     = w_ack;
   assign w_pop      = fifo_rd_i && (r_level != '0);

`ifdef VGA_WB_FETCH_DBLBUF_EN
   logic r_vbsel;

   // The reload targets the buffer selected after this frame's toggle.
   assign w_reloadBase = r_vbsel ? vbase0_i : vbase1_i;
   assign vbsel_o      = r_vbsel;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_vbsel <= 1'b0;
      end else if (w_ack && w_lastWord) begin
         r_vbsel <= ~r_vbsel;
      end
   end
`else
   assign w_reloadBase = vbase0_i;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) w_nextState = S_WAIT;
         end
         S_WAIT: begin
            if (!ctrl_en_i)  w_nextState = S_IDLE;
            else if (w_room) w_nextState = S_BUS;
         end
         S_BUS: begin
            if (w_err)           w_nextState = S_IDLE;
            else if (w_burstEnd) w_nextState = (r_stop || !ctrl_en_i) ? S_IDLE : S_WAIT;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // A disable seen anywhere in a burst is remembered so the burst ends in IDLE.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_adr   <= '0;
         r_count <= '0;
         r_beat  <= '0;
         r_frame <= 1'b0;
         r_err   <= 1'b0;
         r_stop  <= 1'b0;
      end else begin
         r_frame <= w_ack && w_lastWord;
         if (w_err) r_err <= 1'b1;
         if (!w_inBus) begin
            r_beat <= '0;
            r_stop <= 1'b0;
         end else if (!ctrl_en_i) begin
            r_stop <= 1'b1;
         end
         if ((r_state == S_IDLE) && w_start) begin
            r_adr   <= vbase0_i;
            r_count <= '0;
         end
         if (w_ack) begin
            r_beat <= r_beat + BW'(1);
            if (w_lastWord) begin
               r_adr   <= w_reloadBase;
               r_count <= '0;
            end else begin
               r_adr   <= r_adr + AWIDTH'(DWIDTH / 8);
               r_count <= r_count + AWIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (w_push) r_mem[r_wptr] <= wb_dat_i;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
         if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
         if (w_push && !w_pop)      r_level <= r_level + LW'(1);
         else if (w_pop && !w_push) r_level <= r_level - LW'(1);
      end
   end

   assign wb_adr_o     = r_adr;
   assign wb_sel_o     = '1;
   assign wb_we_o      = 1'b0;
   assign wb_cyc_o     = w_inBus;
   assign wb_stb_o     = w_inBus;
   assign fifo_q_o     = r_mem[r_rptr];
   assign fifo_empty_o = (r_level == '0);
   assign frame_o      = r_frame;
   assign err_o        = r_err;

endmodule

// File: tb/tb_vga_wb_fetch.sv
// Scoreboard bench for vga_wb_fetch with a latency-configurable Wishbone slave.
// Exercises the double-buffer scenario when VGA_WB_FETCH_DBLBUF_EN is defined.
module tb_vga_wb_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        ctrlEn;
   logic [31:0] vbase0;
   logic [31:0] vlen;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        fifoRd;
   logic [31:0] fifo_q_o;
   logic        fifo_empty_o;
   logic        frame_o;
   logic        err_o;
`ifdef VGA_WB_FETCH_DBLBUF_EN
   logic [31:0] vbase1;
   logic        vbsel_o;
   logic        vbselAt[$];
`endif

   int          nTests = 0;
   int          nFail = 0;
   int          slaveLat = 1;
   int          errAt = 0;
   logic        slvAck;
   logic        slvErr;
   int          slvCnt;
   int          slvResp;
   logic [31:0] ackAdrQ[$];
   int          frameAt[$];
   int          cycRises;
   logic        prevCyc;
   logic [31:0] expQ[$];

   always #5 clk = ~clk;

   vga_wb_fetch dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .ctrl_en_i    (ctrlEn),
      .vbase0_i     (vbase0),
`ifdef VGA_WB_FETCH_DBLBUF_EN
      .vbase1_i     (vbase1),
      .vbsel_o      (vbsel_o),
`endif
      .vlen_i       (vlen),
      .wb_adr_o     (wb_adr_o),
      .wb_dat_i     (wb_dat_i),
      .wb_sel_o     (wb_sel_o),
      .wb_we_o      (wb_we_o),
      .wb_stb_o     (wb_stb_o),
      .wb_cyc_o     (wb_cyc_o),
      .wb_ack_i     (wb_ack_i),
      .wb_err_i     (wb_err_i),
      .fifo_rd_i    (fifoRd),
      .fifo_q_o     (fifo_q_o),
      .fifo_empty_o (fifo_empty_o),
      .frame_o      (frame_o),
      .err_o        (err_o)
   );

   function automatic logic [31:0] dataOf(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
   endfunction

   assign wb_dat_i = dataOf(wb_adr_o);
   assign wb_ack_i = slvAck;
   assign wb_err_i = slvErr;

   // Slave answers each strobe slaveLat cycles later; response number errAt of a cycle is an error.
   always @(posedge clk) begin
      if (rst || !wb_cyc_o) begin
         slvAck  <= 1'b0;
         slvErr  <= 1'b0;
         slvCnt  <= 0;
         slvResp <= 0;
      end else if (slvAck || slvErr) begin
         slvAck <= 1'b0;
         slvErr <= 1'b0;
         slvCnt <= 0;
      end else if (wb_stb_o) begin
         if (slvCnt >= slaveLat - 1) begin
            if (errAt != 0 && slvResp + 1 == errAt) slvErr <= 1'b1;
            else                                    slvAck <= 1'b1;
            slvResp <= slvResp + 1;
            slvCnt  <= 0;
         end else begin
            slvCnt <= slvCnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         ackAdrQ.delete();
         frameAt.delete();
`ifdef VGA_WB_FETCH_DBLBUF_EN
         vbselAt.delete();
`endif
         cycRises = 0;
         prevCyc  = 1'b0;
      end else begin
         if (frame_o) begin
            frameAt.push_back(ackAdrQ.size());
`ifdef VGA_WB_FETCH_DBLBUF_EN
            vbselAt.push_back(vbsel_o);
`endif
         end
         if (wb_cyc_o && wb_stb_o && slvAck) ackAdrQ.push_back(wb_adr_o);
         if (wb_cyc_o && !prevCyc) cycRises = cycRises + 1;
         prevCyc = wb_cyc_o;
      end
   end

   task automatic doReset();
      rst      = 1'b1;
      ctrlEn   = 1'b0;
      fifoRd   = 1'b0;
      slaveLat = 1;
      errAt    = 0;
      expQ.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      ctrlEn = 1'b1;
      fifoRd = 1'b0;
      vbase0 = 32'h100;
      vlen   = 32'd8;
      repeat (3) @(negedge clk);
      nTests++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin nFail++; $display("[TB] FAIL reset_cyc: got cyc=%b stb=%b expected 0/0", wb_cyc_o, wb_stb_o); end
      nTests++; if (wb_adr_o !== 32'h0) begin nFail++; $display("[TB] FAIL reset_adr: got %h expected 0", wb_adr_o); end
      nTests++; if (fifo_empty_o !== 1'b1) begin nFail++; $display("[TB] FAIL reset_empty: got %b expected 1", fifo_empty_o); end
      nTests++; if (frame_o !== 1'b0 || err_o !== 1'b0) begin nFail++; $display("[TB] FAIL reset_flags: got frame=%b err=%b expected 0/0", frame_o, err_o); end
      nTests++; if (wb_sel_o !== 4'hF || wb_we_o !== 1'b0) begin nFail++; $display("[TB] FAIL reset_selwe: got sel=%h we=%b expected F/0", wb_sel_o, wb_we_o); end
      ctrlEn = 1'b0;
   endtask

   task automatic test_full_frame();
      bit ok;
      logic [31:0] expWord;
      doReset();
      slaveLat = 3;
      vbase0   = 32'h100;
      vlen     = 32'd8;
      for (int i = 0; i < 16; i++) expQ.push_back(dataOf(32'h100 + 32'(4 * (i % 8))));
      ctrlEn = 1'b1;
      ok = 0;
      for (int c = 0; c < 600 && !ok; c++) begin @(negedge clk); ok = (ackAdrQ.size() >= 16) && !wb_cyc_o; end
      nTests++; if (!ok) begin nFail++; $display("[TB] FAIL full_fill: got %0d acks expected 16 before timeout", ackAdrQ.size()); end
      repeat (20) @(negedge clk);
      nTests++; if (ackAdrQ.size() != 16 || wb_cyc_o !== 1'b0) begin nFail++; $display("[TB] FAIL full_hold: got %0d acks cyc=%b expected 16 acks cyc=0", ackAdrQ.size(), wb_cyc_o); end
      for (int i = 0; i < 16 && i < ackAdrQ.size(); i++) begin
         nTests++; if (ackAdrQ[i] !== 32'h100 + 32'(4 * (i % 8))) begin nFail++; $display("[TB] FAIL full_adr%0d: got %h expected %h", i, ackAdrQ[i], 32'h100 + 32'(4 * (i % 8))); end
      end
      nTests++; if (frameAt.size() != 2 || frameAt[0] != 8 || frameAt[1] != 16) begin nFail++; $display("[TB] FAIL full_frame: got %0d pulses expected pulses after ack 8 and 16", frameAt.size()); end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         expWord = expQ.pop_front();
         nTests++; if (fifo_empty_o !== 1'b0 || fifo_q_o !== expWord) begin nFail++; $display("[TB] FAIL full_pop%0d: got %h expected %h", i, fifo_q_o, expWord); end
         fifoRd = 1'b1;
      end
      @(negedge clk); fifoRd = 1'b0;
      ok = 1;
      repeat (10) begin @(negedge clk); if (wb_cyc_o) ok = 0; end
      nTests++; if (!ok) begin nFail++; $display("[TB] FAIL full_nostart7: got cyc=1 expected 0 with 9 words queued"); end
      expWord = expQ.pop_front();
      nTests++; if (fifo_q_o !== expWord) begin nFail++; $display("[TB] FAIL full_pop7: got %h expected %h", fifo_q_o, expWord); end
      fifoRd = 1'b1;
      @(negedge clk); fifoRd = 1'b0;
      ok = 0;
      for (int c = 0; c < 4 && !ok; c++) begin @(negedge clk); ok = wb_cyc_o; end
      nTests++; if (!ok) begin nFail++; $display("[TB] FAIL full_restart: got cyc=0 expected 1 after 8 pops"); end
      ctrlEn = 1'b0;
   endtask

   task automatic test_short_frame();
      bit ok;
      logic [31:0] expWord;
      doReset();
      vbase0 = 32'h100;
      vlen   = 32'd5;
      for (int i = 0; i < 10; i++) expQ.push_back(dataOf(32'h100 + 32'(4 * (i % 5))));
      ctrlEn = 1'b1;
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin @(negedge clk); ok = (ackAdrQ.size() >= 6); end
      ctrlEn = 1'b0;
      nTests++; if (!ok || ackAdrQ[5] !== 32'h100) begin nFail++; $display("[TB] FAIL short_wrap: got %0d acks, 6th adr %h expected 00000100", ackAdrQ.size(), ok ? ackAdrQ[5] : 32'h0); end
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin @(negedge clk); ok = !wb_cyc_o; end
      repeat (20) @(negedge clk);
      nTests++; if (ackAdrQ.size() != 10 || cycRises != 2) begin nFail++; $display("[TB] FAIL short_count: got %0d acks %0d cycles expected 10 acks 2 cycles", ackAdrQ.size(), cycRises); end
      nTests++; if (frameAt.size() != 2 || frameAt[0] != 5 || frameAt[1] != 10) begin nFail++; $display("[TB] FAIL short_frame: got %0d pulses expected pulses after ack 5 and 10", frameAt.size()); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         expWord = expQ.pop_front();
         nTests++; if (fifo_empty_o !== 1'b0 || fifo_q_o !== expWord) begin nFail++; $display("[TB] FAIL short_pop%0d: got %h expected %h", i, fifo_q_o, expWord); end
         fifoRd = 1'b1;
      end
      @(negedge clk); fifoRd = 1'b0;
      nTests++; if (fifo_empty_o !== 1'b1) begin nFail++; $display("[TB] FAIL short_empty: got %b expected 1", fifo_empty_o); end
   endtask

   task automatic test_throttle();
      bit ok;
      int popped;
      int cycAt;
      logic [31:0] expWord;
      doReset();
      vbase0 = 32'h100;
      vlen   = 32'd64;
      for (int i = 0; i < 40; i++) expQ.push_back(dataOf(32'h100 + 32'(4 * i)));
      ctrlEn = 1'b1;
      ok = 0;
      for (int c = 0; c < 300 && !ok; c++) begin @(negedge clk); ok = (ackAdrQ.size() >= 16) && !wb_cyc_o; end
      repeat (5) @(negedge clk);
      nTests++; if (!ok || ackAdrQ.size() != 16) begin nFail++; $display("[TB] FAIL thr_full: got %0d acks expected 16", ackAdrQ.size()); end
      popped = 0;
      cycAt  = -1;
      for (int c = 0; c < 400 && popped < 40; c++) begin
         @(negedge clk);
         if (cycAt < 0 && wb_cyc_o) cycAt = popped;
         if (!fifo_empty_o) begin
            expWord = expQ.pop_front();
            nTests++; if (fifo_q_o !== expWord) begin nFail++; $display("[TB] FAIL thr_pop%0d: got %h expected %h", popped, fifo_q_o, expWord); end
            fifoRd = 1'b1;
            popped++;
         end else begin
            fifoRd = 1'b0;
         end
      end
      @(negedge clk); fifoRd = 1'b0;
      ctrlEn = 1'b0;
      nTests++; if (popped != 40) begin nFail++; $display("[TB] FAIL thr_drain: got %0d words expected 40", popped); end
      nTests++; if (cycAt != 9) begin nFail++; $display("[TB] FAIL thr_restart: got cyc after %0d pops expected 9", cycAt); end
   endtask

   task automatic test_bus_error();
      bit ok;
      logic [31:0] expWord;
      doReset();
      errAt  = 3;
      vbase0 = 32'h100;
      vlen   = 32'd8;
      for (int i = 0; i < 2; i++) expQ.push_back(dataOf(32'h100 + 32'(4 * i)));
      ctrlEn = 1'b1;
      ok = 0;
      for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = slvErr; end
      @(negedge clk);
      nTests++; if (!ok || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin nFail++; $display("[TB] FAIL err_drop: got cyc=%b stb=%b expected 0/0", wb_cyc_o, wb_stb_o); end
      nTests++; if (err_o !== 1'b1) begin nFail++; $display("[TB] FAIL err_flag: got %b expected 1", err_o); end
      ctrlEn = 1'b0;
      repeat (3) @(negedge clk);
      ctrlEn = 1'b1;
      repeat (20) @(negedge clk);
      nTests++; if (ackAdrQ.size() != 2 || cycRises != 1 || err_o !== 1'b1) begin nFail++; $display("[TB] FAIL err_stuck: got %0d acks %0d cycles err=%b expected 2/1/1", ackAdrQ.size(), cycRises, err_o); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         expWord = expQ.pop_front();
         nTests++; if (fifo_empty_o !== 1'b0 || fifo_q_o !== expWord) begin nFail++; $display("[TB] FAIL err_pop%0d: got %h expected %h", i, fifo_q_o, expWord); end
         fifoRd = 1'b1;
      end
      @(negedge clk); fifoRd = 1'b0;
      nTests++; if (fifo_empty_o !== 1'b1) begin nFail++; $display("[TB] FAIL err_empty: got %b expected 1", fifo_empty_o); end
      ctrlEn = 1'b0;
   endtask

   task automatic test_enable_drop();
      bit ok;
      logic [31:0] expWord;
      doReset();
      slaveLat = 3;
      vbase0   = 32'h100;
      vlen     = 32'd64;
      for (int i = 0; i < 8; i++) expQ.push_back(dataOf(32'h100 + 32'(4 * i)));
      for (int i = 0; i < 8; i++) expQ.push_back(dataOf(32'h300 + 32'(4 * i)));
      ctrlEn = 1'b1;
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin @(negedge clk); ok = (ackAdrQ.size() >= 3); end
      ctrlEn = 1'b0;
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin @(negedge clk); ok = !wb_cyc_o; end
      repeat (20) @(negedge clk);
      nTests++; if (ackAdrQ.size() != 8 || wb_cyc_o !== 1'b0) begin nFail++; $display("[TB] FAIL en_finish: got %0d acks cyc=%b expected 8 acks cyc=0", ackAdrQ.size(), wb_cyc_o); end
      nTests++; if (fifo_empty_o !== 1'b0) begin nFail++; $display("[TB] FAIL en_kept: got empty=%b expected 0", fifo_empty_o); end
      vbase0 = 32'h300;
      ctrlEn = 1'b1;
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin @(negedge clk); ok = (ackAdrQ.size() >= 9); end
      ctrlEn = 1'b0;
      nTests++; if (!ok || ackAdrQ[8] !== 32'h300) begin nFail++; $display("[TB] FAIL en_rebase: got adr %h expected 00000300", ok ? ackAdrQ[8] : 32'h0); end
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin @(negedge clk); ok = !wb_cyc_o; end
      nTests++; if (ackAdrQ.size() != 16) begin nFail++; $display("[TB] FAIL en_second: got %0d acks expected 16", ackAdrQ.size()); end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         expWord = expQ.pop_front();
         nTests++; if (fifo_empty_o !== 1'b0 || fifo_q_o !== expWord) begin nFail++; $display("[TB] FAIL en_pop%0d: got %h expected %h", i, fifo_q_o, expWord); end
         fifoRd = 1'b1;
      end
      @(negedge clk); fifoRd = 1'b0;
      nTests++; if (fifo_empty_o !== 1'b1) begin nFail++; $display("[TB] FAIL en_empty: got %b expected 1", fifo_empty_o); end
   endtask

`ifdef VGA_WB_FETCH_DBLBUF_EN
   task automatic test_dblbuf();
      bit ok;
      logic [31:0] expAdr;
      doReset();
      vbase0 = 32'h100;
      vbase1 = 32'h800;
      vlen   = 32'd4;
      ctrlEn = 1'b1;
      ok = 0;
      for (int c = 0; c < 300 && !ok; c++) begin @(negedge clk); ok = (ackAdrQ.size() >= 12) && !wb_cyc_o; end
      repeat (10) @(negedge clk);
      ctrlEn = 1'b0;
      nTests++; if (ackAdrQ.size() != 12) begin nFail++; $display("[TB] FAIL dbl_count: got %0d acks expected 12", ackAdrQ.size()); end
      for (int i = 0; i < 12 && i < ackAdrQ.size(); i++) begin
         expAdr = (((i / 4) % 2) == 0 ? 32'h100 : 32'h800) + 32'(4 * (i % 4));
         nTests++; if (ackAdrQ[i] !== expAdr) begin nFail++; $display("[TB] FAIL dbl_adr%0d: got %h expected %h", i, ackAdrQ[i], expAdr); end
      end
      nTests++; if (vbselAt.size() != 3 || vbselAt[0] !== 1'b1 || vbselAt[1] !== 1'b0 || vbselAt[2] !== 1'b1) begin nFail++; $display("[TB] FAIL dbl_vbsel: got %0d frame pulses expected 3 with vbsel 1,0,1", vbselAt.size()); end
      nTests++; if (vbsel_o !== 1'b1) begin nFail++; $display("[TB] FAIL dbl_final: got %b expected 1", vbsel_o); end
   endtask
`endif

   initial begin
      rst    = 1'b1;
      ctrlEn = 1'b0;
      fifoRd = 1'b0;
      vbase0 = 32'h0;
      vlen   = 32'h0;
`ifdef VGA_WB_FETCH_DBLBUF_EN
      vbase1 = 32'h0;
`endif
      test_reset();
      test_full_frame();
      test_short_frame();
      test_throttle();
      test_bus_error();
      test_enable_drop();
`ifdef VGA_WB_FETCH_DBLBUF_EN
      test_dblbuf();
`endif
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
